// File: rtl/dino_runner_core.sv
// Endless-runner game core: jumping player, scrolling obstacles, collision, game over and score.
// Pixel outputs are combinational (0 latency); all motion advances on frame_tick. There is no backpressure.
module dino_runner_core #(
   parameter int N_OBST       = 2,
   parameter int POS_W        = 11,
   parameter int SCREEN_W     = 640,
   parameter int OBST_SPACING = 320,
   parameter int OBST_SIZE    = 10,
   parameter int SPEED        = 2,
   parameter int DINO_X       = 64,
   parameter int DINO_W       = 16,
   parameter int DINO_H       = 16,
   parameter int GROUND_Y     = 400,
   parameter int JUMP_H       = 40,
   parameter int JUMP_STEP    = 2,
   parameter int SCORE_W      = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               jump_btn,
   input  logic               display_on,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   output logic               dino_px,
   output logic               obst_px,
   output logic               game_over,
   output logic [SCORE_W-1:0] score
);

   localparam int HW   = $clog2(JUMP_H + 1);
   localparam int CW   = POS_W + 1;
   localparam int JS_I = (JUMP_STEP > JUMP_H) ? JUMP_H : JUMP_STEP;
   localparam logic [HW-1:0] H_MAX  = HW'(JUMP_H);
   localparam logic [HW-1:0] H_STEP = HW'(JS_I);
   localparam logic [SCORE_W+2:0] SAT = {3'b000, {SCORE_W{1'b1}}};

   generate
      if (GROUND_Y < DINO_H + JUMP_H) begin : g_geom_check
         $error("dino_runner_core: GROUND_Y-DINO_H-JUMP_H must not be negative");
      end
      if (N_OBST < 1 || N_OBST > 4) begin : g_nobst_check
         $error("dino_runner_core: N_OBST must be in 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {RUN, RISE, FALL, DEAD} state_t;

   state_t              state_q, state_d;
   logic [HW-1:0]       height_q, height_d;
   logic [POS_W-1:0]    obst_x [N_OBST];
   logic [SCORE_W-1:0]  score_q;
   logic [SCORE_W+2:0]  score_sum;
   logic                btn_prev, jump_edge;
   logic                hit_flag, hit_now, collide;
   logic                move, restart;
   logic [CW-1:0]       px, py, dino_top;
   logic                dino_in;
   logic [N_OBST-1:0]   obst_in, cleared;
   logic [2:0]          n_clr;

   assign px        = CW'(pix_x);
   assign py        = CW'(pix_y);
   assign dino_top  = CW'(GROUND_Y - DINO_H) - CW'(height_q);
   assign jump_edge = jump_btn & ~btn_prev;

   always_comb begin
      dino_in = display_on
             && (px >= CW'(DINO_X)) && (px < CW'(DINO_X + DINO_W))
             && (py >= dino_top)    && (py < dino_top + CW'(DINO_H));
   end

   // Obstacles parked at or beyond SCREEN_W are off-screen and never drawn.
   always_comb begin
      obst_in = '0;
      for (int i = 0; i < N_OBST; i++) begin
         obst_in[i] = display_on
                   && (CW'(obst_x[i]) < CW'(SCREEN_W))
                   && (px >= CW'(obst_x[i]))
                   && (px < CW'(obst_x[i]) + CW'(OBST_SIZE))
                   && (py >= CW'(GROUND_Y - OBST_SIZE))
                   && (py < CW'(GROUND_Y));
      end
   end

   assign dino_px   = dino_in;
   assign obst_px   = |obst_in;
   assign hit_now   = dino_in & (|obst_in);
   assign collide   = frame_tick & (hit_flag | hit_now);
   assign game_over = (state_q == DEAD);
   assign score     = score_q;

   always_comb begin
      state_d  = state_q;
      height_d = height_q;
      move     = 1'b0;
      restart  = 1'b0;
      case (state_q)
         RUN: begin
            if (collide) begin
               state_d = DEAD;
            end else begin
               move = frame_tick;
               if (jump_edge) state_d = RISE;
            end
         end
         RISE: begin
            if (collide) begin
               state_d = DEAD;
            end else if (frame_tick) begin
               move = 1'b1;
               if (H_MAX - height_q <= H_STEP) begin
                  height_d = H_MAX;
                  state_d  = FALL;
               end else begin
                  height_d = height_q + H_STEP;
               end
            end
         end
         FALL: begin
            if (collide) begin
               state_d = DEAD;
            end else if (frame_tick) begin
               move = 1'b1;
               if (height_q <= H_STEP) begin
                  height_d = '0;
                  state_d  = RUN;
               end else begin
                  height_d = height_q - H_STEP;
               end
            end
         end
         DEAD: begin
            if (jump_edge) begin
               restart  = 1'b1;
               state_d  = RUN;
               height_d = '0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      cleared = '0;
      n_clr   = '0;
      for (int i = 0; i < N_OBST; i++) begin
         cleared[i] = move && (CW'(obst_x[i]) < CW'(SPEED));
         n_clr      = n_clr + 3'(cleared[i]);
      end
      score_sum = {3'b000, score_q} + (SCORE_W + 3)'(n_clr);
   end

   // Edge detector samples even in reset so a held button cannot fire afterwards.
   always_ff @(posedge clk) begin
      btn_prev <= jump_btn;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         height_q <= '0;
      end else begin
         state_q  <= state_d;
         height_q <= height_d;
      end
   end

   // Restart from DEAD lands on exactly the reset picture.
   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         score_q  <= '0;
         hit_flag <= 1'b0;
         for (int i = 0; i < N_OBST; i++) begin
            obst_x[i] <= POS_W'(SCREEN_W + i * OBST_SPACING);
         end
      end else begin
         if (move) begin
            for (int i = 0; i < N_OBST; i++) begin
               if (cleared[i]) obst_x[i] <= POS_W'(SCREEN_W);
               else            obst_x[i] <= obst_x[i] - POS_W'(SPEED);
            end
            score_q <= (score_sum > SAT) ? SAT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
         end
         if (frame_tick)                        hit_flag <= 1'b0;
         else if (hit_now && state_q != DEAD)   hit_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dino_runner_core.sv
// Self-checking bench for dino_runner_core: pixel table, jump/collision/restart sequences, score saturation.
module tb_dino_runner_core;

   localparam int ST_RUN = 0, ST_RISE = 1, ST_FALL = 2, ST_DEAD = 3;

   logic       clk = 1'b0;
   logic       rst_n, frame_tick, jump_btn, display_on;
   logic [9:0] pix_x, pix_y;
   logic       dino_px, obst_px, game_over;
   logic [9:0] score;
   logic       frame_tick2;
   logic       dino_px2, obst_px2, game_over2;
   logic [1:0] score2;

   always #5 clk = ~clk;

   dino_runner_core u_dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jump_btn(jump_btn),
      .display_on(display_on), .pix_x(pix_x), .pix_y(pix_y),
      .dino_px(dino_px), .obst_px(obst_px), .game_over(game_over), .score(score)
   );

   dino_runner_core #(.SCREEN_W(40), .OBST_SPACING(20), .SCORE_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick2), .jump_btn(1'b0),
      .display_on(1'b0), .pix_x(10'd0), .pix_y(10'd0),
      .dino_px(dino_px2), .obst_px(obst_px2), .game_over(game_over2), .score(score2)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      string name;
      int    exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int x;
      int y;
      bit disp;
      bit e_dino;
      bit e_obst;
   } vec_t;
   vec_t tbl[16];

   int m_h, m_st, m_score;
   int m_ox[2];
   bit m_hit;

   task automatic expect_val(input string n, input int e);
      sb_t s;
      s.name = n;
      s.exp  = e;
      sb_q.push_back(s);
   endtask

   task automatic got(input int a);
      sb_t s;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty actual=%0d required=queued_entry", a);
      end else begin
         s = sb_q.pop_front();
         if (a != s.exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", s.name, a, s.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_tick();
      if (m_st != ST_DEAD) begin
         if (m_hit) begin
            m_st = ST_DEAD;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (m_ox[i] >= 2) m_ox[i] -= 2;
               else begin
                  m_ox[i] = 640;
                  if (m_score < 1023) m_score++;
               end
            end
            if (m_st == ST_RISE) begin
               m_h = (m_h + 2 > 40) ? 40 : m_h + 2;
               if (m_h == 40) m_st = ST_FALL;
            end else if (m_st == ST_FALL) begin
               m_h = (m_h < 2) ? 0 : m_h - 2;
               if (m_h == 0) m_st = ST_RUN;
            end
         end
      end
      m_hit = 1'b0;
   endfunction

   function automatic void model_reset();
      m_h = 0; m_st = ST_RUN; m_score = 0; m_hit = 1'b0;
      m_ox[0] = 640; m_ox[1] = 960;
   endfunction

   function automatic int model_first();
      int f = -1;
      for (int i = 0; i < 2; i++)
         if (m_ox[i] < 640 && (f < 0 || m_ox[i] < f)) f = m_ox[i];
      return f;
   endfunction

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      model_tick();
   endtask

   task automatic press();
      jump_btn = 1'b1;
      step();
      jump_btn = 1'b0;
      step();
      if (m_st == ST_RUN) m_st = ST_RISE;
   endtask

   // Pixel held through one rising edge so the core can register a hit.
   task automatic hit_at(input int x, input int y, input bit disp, input bit exp_hit);
      @(negedge clk);
      pix_x = 10'(x); pix_y = 10'(y); display_on = disp;
      @(posedge clk);
      #1;
      display_on = 1'b0;
      if (exp_hit && m_st != ST_DEAD) m_hit = 1'b1;
   endtask

   // Probe never spans a rising edge, so it cannot create a hit.
   task automatic probe(input int x, input int y, input bit d, output bit dp, output bit op);
      @(negedge clk);
      pix_x = 10'(x); pix_y = 10'(y); display_on = d;
      #1;
      dp = dino_px;
      op = obst_px;
      display_on = 1'b0;
   endtask

   task automatic scan_obst(output int first);
      bit dp, op;
      first = -1;
      for (int x = 0; x < 640 && first < 0; x++) begin
         probe(x, 395, 1'b1, dp, op);
         if (op) first = x;
      end
   endtask

   task automatic meas_height(output int h);
      bit dp, op;
      h = -1;
      for (int y = 330; y < 400 && h < 0; y++) begin
         probe(65, y, 1'b1, dp, op);
         if (dp) h = 384 - y;
      end
   endtask

   task automatic check_height(input string n);
      int h;
      expect_val(n, m_h);
      meas_height(h);
      got(h);
   endtask

   task automatic observe(input string tag);
      int h, f;
      expect_val({tag, "_game_over"}, (m_st == ST_DEAD) ? 1 : 0);
      expect_val({tag, "_score"}, m_score);
      expect_val({tag, "_height"}, m_h);
      expect_val({tag, "_first_obst_x"}, model_first());
      got(int'(game_over));
      got(int'(score));
      meas_height(h);
      got(h);
      scan_obst(f);
      got(f);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit dp, op;
      int f, guard;
      int m2_ox[2];
      int m2_s, c;

      // Obstacle 0 at 100, obstacle 1 at 420, player on the ground.
      tbl[0]  = '{64, 384, 1, 1, 0};
      tbl[1]  = '{63, 390, 1, 0, 0};
      tbl[2]  = '{79, 399, 1, 1, 0};
      tbl[3]  = '{80, 390, 1, 0, 0};
      tbl[4]  = '{70, 383, 1, 0, 0};
      tbl[5]  = '{70, 400, 1, 0, 0};
      tbl[6]  = '{70, 390, 0, 0, 0};
      tbl[7]  = '{100, 390, 1, 0, 1};
      tbl[8]  = '{99, 395, 1, 0, 0};
      tbl[9]  = '{109, 399, 1, 0, 1};
      tbl[10] = '{110, 395, 1, 0, 0};
      tbl[11] = '{105, 389, 1, 0, 0};
      tbl[12] = '{105, 400, 1, 0, 0};
      tbl[13] = '{429, 395, 1, 0, 1};
      tbl[14] = '{430, 395, 1, 0, 0};
      tbl[15] = '{105, 395, 0, 0, 0};

      rst_n = 1'b0; frame_tick = 1'b0; frame_tick2 = 1'b0; jump_btn = 1'b1;
      display_on = 1'b0; pix_x = '0; pix_y = '0;
      repeat (3) step();
      rst_n = 1'b1;
      model_reset();
      step(); step();
      jump_btn = 1'b0;
      step();
      observe("reset");

      repeat (3) tick();
      observe("held_btn_no_jump");

      // Jump edge coinciding with a frame tick: obstacles move, height does not.
      jump_btn = 1'b1; frame_tick = 1'b1;
      step();
      jump_btn = 1'b0; frame_tick = 1'b0;
      model_tick();
      m_st = ST_RISE;
      step();
      check_height("jump_start_height");
      repeat (10) tick();
      check_height("rise_10");
      press();
      repeat (10) tick();
      observe("apex");
      tick();
      check_height("fall_first");
      repeat (19) tick();
      check_height("landed");
      tick();
      check_height("run_after_land");

      guard = 0;
      while (m_ox[0] != 100 && guard < 400) begin tick(); guard++; end
      observe("pre_table");
      for (int i = 0; i < 16; i++) begin
         expect_val($sformatf("pix_tbl%0d", i), int'(tbl[i].e_dino) * 2 + int'(tbl[i].e_obst));
         probe(tbl[i].x, tbl[i].y, tbl[i].disp, dp, op);
         got(int'(dp) * 2 + int'(op));
      end

      tick();
      expect_val("decrement", model_first());
      scan_obst(f);
      got(f);

      guard = 0;
      while (m_ox[0] != 80 && guard < 100) begin tick(); guard++; end
      hit_at(80, 395, 1'b1, 1'b0);
      hit_at(79, 395, 1'b1, 1'b0);
      tick();
      hit_at(79, 395, 1'b0, 1'b0);
      tick();
      expect_val("touch_and_blank_no_death", 0);
      got(int'(game_over));
      hit_at(77, 395, 1'b1, 1'b1);
      expect_val("sticky_before_tick", 0);
      got(int'(game_over));
      press();
      tick();
      observe("dead");
      repeat (2) tick();
      observe("frozen");
      expect_val("dead_picture", 2);
      probe(70, 390, 1'b1, dp, op);
      got(int'(dp) * 2 + int'(op));

      jump_btn = 1'b1;
      step();
      expect_val("restart_game_over", 0);
      got(int'(game_over));
      model_reset();
      jump_btn = 1'b0;
      step();
      observe("restart");

      guard = 0;
      while (m_ox[0] != 40 && guard < 400) begin tick(); guard++; end
      press();
      repeat (20) tick();
      check_height("airborne_apex");
      hit_at(5, 395, 1'b1, 1'b0);
      tick();
      observe("wrap_airborne");

      m2_ox[0] = 40; m2_ox[1] = 60; m2_s = 0;
      for (int t = 1; t <= 63; t++) begin
         frame_tick2 = 1'b1;
         step();
         frame_tick2 = 1'b0;
         c = 0;
         for (int i = 0; i < 2; i++) begin
            if (m2_ox[i] >= 2) m2_ox[i] -= 2;
            else begin m2_ox[i] = 40; c++; end
         end
         if (c > 0) begin
            m2_s = (m2_s + c > 3) ? 3 : m2_s + c;
            expect_val($sformatf("sat_score_t%0d", t), m2_s);
            got(int'(score2));
         end
      end
      expect_val("sat_idle_outputs", 0);
      got(int'(game_over2) + int'(dino_px2) + int'(obst_px2));

      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
